kernel_mac_sequencer: RTL

Control block that drives the register file's kernel hardware to compute one 3x3 convolution output pixel. On each START it:
- clears the accumulator register R14;
- loads each packed kernel row into R12;
- writes the nine streamed pixels into R13, so the register file multiplies and accumulates;
- reads R14 back and presents it on a valid/ready result port.

It is the initiator for the register file's specific-purpose R12/R13/R14 datapath. It sits between the image-streaming front end and the register file write/read ports.

---
 rtl/kernel_mac_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/kernel_mac_sequencer.sv
// ---------------------------------------------------------------------------
// kernel_mac_sequencer
//
// Sequences one 3x3 convolution pixel through the register file's R12/R13/R14
// multiply-accumulate datapath: clear R14, then for each kernel row load the
// packed row into R12 and stream three pixels into R13, then read R14 back
// and present it on a valid/ready result port.
//
// Configuration macro: KERNEL_SATURATE_EN
//   defined   : the R14 value is clamped to 0 .. 2^(BITS/3)-1 before it is
//               stored to result_o.
//   undefined : result_o is the raw R14 value.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           start request, accepted only while idle
//   krow0_i..krow2_i  packed kernel rows (BITS/3-bit signed coefficients,
//                     MSB-first), sampled when start is accepted
//   busy_o            high whenever the sequencer is not idle
//   pix_data_i        pixel value
//   pix_valid_i       pixel valid
//   pix_ready_o       sequencer can accept a pixel (decoded from state only)
//   rf_addrs_rd_o     register file write address
//   rf_wrt_data_o     register file write data
//   rf_wrt_ena_o      register file write enable
//   rf_addrs_rn_o     register file read address, constant 14
//   rf_rn_data_i      register file read data (combinational)
//   result_o          convolution result, stable while result_valid_o is high
//   result_valid_o    result valid
//   result_ready_i    consumer accepts the result
// ---------------------------------------------------------------------------
module kernel_mac_sequencer #(
  parameter int BITS = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [BITS-1:0] krow0_i,
  input  logic [BITS-1:0] krow1_i,
  input  logic [BITS-1:0] krow2_i,
  output logic            busy_o,
  input  logic [BITS-1:0] pix_data_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  output logic [3:0]      rf_addrs_rd_o,
  output logic [BITS-1:0] rf_wrt_data_o,
  output logic            rf_wrt_ena_o,
  output logic [3:0]      rf_addrs_rn_o,
  input  logic [BITS-1:0] rf_rn_data_i,
  output logic [BITS-1:0] result_o,
  output logic            result_valid_o,
  input  logic            result_ready_i
);

  localparam int COEF = BITS / 3;

  localparam logic [3:0] ADDR_KROW = 4'd12;
  localparam logic [3:0] ADDR_PIX  = 4'd13;
  localparam logic [3:0] ADDR_ACC  = 4'd14;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_LOAD_ROW = 3'd2;
  localparam logic [2:0] S_PIXEL    = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_OUT      = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [1:0]      row_cnt_q, row_cnt_d;
  logic [1:0]      col_cnt_q, col_cnt_d;
  logic [BITS-1:0] krow_q [3];
  logic [BITS-1:0] krow_d [3];
  logic [BITS-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic [BITS-1:0] krow_sel;
  logic [BITS-1:0] drain_value;

  // Row currently being loaded into R12.
  always_comb begin
    case (row_cnt_q)
      2'd0:    krow_sel = krow_q[0];
      2'd1:    krow_sel = krow_q[1];
      default: krow_sel = krow_q[2];
    endcase
  end

  // Value captured from R14 in DRAIN.
`ifdef KERNEL_SATURATE_EN
  localparam logic [BITS-1:0] SAT_MAX = {{(BITS-COEF){1'b0}}, {COEF{1'b1}}};

  always_comb begin
    if (rf_rn_data_i[BITS-1]) begin
      drain_value = '0;
    end else if (rf_rn_data_i > SAT_MAX) begin
      drain_value = SAT_MAX;
    end else begin
      drain_value = rf_rn_data_i;
    end
  end
`else
  always_comb begin
    drain_value = rf_rn_data_i;
  end
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    col_cnt_d      = col_cnt_q;
    krow_d         = krow_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    rf_addrs_rd_o  = 4'd0;
    rf_wrt_data_o  = '0;
    rf_wrt_ena_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          krow_d[0] = krow0_i;
          krow_d[1] = krow1_i;
          krow_d[2] = krow2_i;
          row_cnt_d = 2'd0;
          col_cnt_d = 2'd0;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        rf_addrs_rd_o = ADDR_ACC;
        rf_wrt_ena_o  = 1'b1;
        state_d       = S_LOAD_ROW;
      end

      S_LOAD_ROW: begin
        rf_addrs_rd_o = ADDR_KROW;
        rf_wrt_data_o = krow_sel;
        rf_wrt_ena_o  = 1'b1;
        col_cnt_d     = 2'd0;
        state_d       = S_PIXEL;
      end

      S_PIXEL: begin
        // pix_ready_o is high throughout this state, so valid alone is the
        // handshake; a stall cycle leaves the write port idle.
        if (pix_valid_i) begin
          rf_addrs_rd_o = ADDR_PIX;
          rf_wrt_data_o = pix_data_i;
          rf_wrt_ena_o  = 1'b1;
          if (col_cnt_q == 2'd2) begin
            col_cnt_d = 2'd0;
            if (row_cnt_q == 2'd2) begin
              state_d = S_DRAIN;
            end else begin
              row_cnt_d = row_cnt_q + 2'd1;
              state_d   = S_LOAD_ROW;
            end
          end else begin
            col_cnt_d = col_cnt_q + 2'd1;
          end
        end
      end

      S_DRAIN: begin
        result_d       = drain_value;
        result_valid_d = 1'b1;
        state_d        = S_OUT;
      end

      S_OUT: begin
        // start_i is deliberately not looked at here.
        if (result_ready_i) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      row_cnt_q      <= 2'd0;
      col_cnt_q      <= 2'd0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      // NOTE: the kernel row store is three ordinary registers, not a RAM
      // macro, so it is cleared with the rest of the state.
      for (int i = 0; i < 3; i++) begin
        krow_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      col_cnt_q      <= col_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      krow_q         <= krow_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign pix_ready_o    = (state_q == S_PIXEL);
  assign rf_addrs_rn_o  = ADDR_ACC;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule
